instr_sequencer: RTL and testbench
==================================

# instr_sequencer

Program sequencer that sits directly upstream of the register/ALU stage. It holds a small loadable program memory and steps a program counter through it. Each instruction is decoded into the `number`, `reg_in` and `oper` fields the register stage consumes, and issued with a valid/ready handshake. Execution runs from address 0 until a halt word or the last address, then reports done.

## Interface
Parameters:
- `DEPTH`, 16: number of program words; power of two, at least 2.
- `PC_W`, 4: program-counter width; must equal log2(`DEPTH`).

Ports:
- Clock and reset: one clock, `clk`; reset is `rst`, synchronous and active-high.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous active-high reset.
- `start` in 1: one-cycle pulse that begins execution at address 0.
- `prog_we` in 1: program-memory write enable.
- `prog_addr` in `PC_W`: write address.
- `prog_data` in 5: instruction word. Bit 4 is halt, [3:2] is number, [1] is reg_in, [0] is oper.
- `issue_valid` out 1: the decoded fields are valid.
- `issue_ready` in 1: downstream accepts the current instruction.
- `number` out 2: operand.
- `reg_in` out 1: destination register select (0 = a0, 1 = a1).
- `oper` out 1: 0 = add, 1 = shift-left.
- `pc` out `PC_W`: address of the current or next instruction.
- `busy` out 1: high in FETCH and ISSUE (and in PAUSE when configured).
- `done` out 1: high in DONE.

## Operation
- State machine states: IDLE, FETCH, ISSUE, DONE, plus PAUSE when configured.
- IDLE or DONE, `start`=1: set pc to 0, go to FETCH. In DONE, also clear `done`.
- FETCH (one cycle):
  - Read memory at pc combinationally.
  - If halt bit = 1: go to DONE; nothing is issued.
  - Otherwise: load bits [3:0] into the output register and go to ISSUE.
- ISSUE:
  - `issue_valid`=1. `number`, `reg_in` and `oper` are held stable until handshake.
  - Handshake is `issue_valid`&&`issue_ready` at a rising edge.
  - On handshake at pc = `DEPTH`-1: go to DONE; pc holds.
  - On handshake otherwise: pc+1, go to FETCH.
  - Without handshake: stay in ISSUE; outputs are unchanged.
- DONE: `done`=1 and holds until `start` or `rst`.
- Program writes:
  - Accepted only in IDLE or DONE; `mem[prog_addr]` ← `prog_data` at the clock edge.
  - `prog_we` in any other state is ignored.
- `start` while `busy`=1 is ignored.
- Field widths are passed through unmodified. The sequencer does no arithmetic beyond pc increment; pc never wraps.

## Timing
- Reset values:
  - `issue_valid`=0, `number`=0, `reg_in`=0, `oper`=0, `pc`=0, `busy`=0, `done`=0; state = IDLE.
  - Every memory word = 5'b10000 (halt).
- Reset mid-operation: the in-flight instruction is abandoned (`issue_valid` drops the next cycle) and memory is cleared.
- Latency: `start` sampled at edge 0 → FETCH during cycle 1 → `issue_valid`=1 during cycle 2.
- Throughput: with `issue_ready` held high, one instruction every 2 cycles.
- Halt at address k: DONE is reached 1 cycle after FETCH of k.
- `start` and `prog_we` in the same IDLE cycle: the write completes at that edge, and FETCH sees the new word.
- `issue_valid` never drops without a handshake, except on `rst`.
- `issue_ready` has no effect outside ISSUE.

## Configuration
- Macro: `INSTR_SEQUENCER_SINGLE_STEP_EN`.
- Defined:
  - Adds input `step` (1 bit) and state PAUSE.
  - After each non-final handshake, pc+1 and go to PAUSE (`busy`=1, `issue_valid`=0).
  - A `step` pulse moves PAUSE → FETCH.
  - `step` outside PAUSE is ignored.
  - `rst` in PAUSE returns to IDLE.
- Undefined: no `step` port and no PAUSE state; the handshake goes straight to FETCH as described above.

## Test plan
- Reset check: assert `rst` for 2 cycles → every output is 0. Then pulse `start` → FETCH finds a halt word at 0 → `done`=1 by cycle 2, and `issue_valid` is never asserted.
- Load-and-run: write 0x05, 0x0A, 0x10 at addresses 0–2, `issue_ready`=1, pulse `start`.
  - Issues number=1/reg_in=0/oper=1, then number=2/reg_in=1/oper=0, two cycles apart.
  - Then `done`=1 with `pc`=2.
- Backpressure: hold `issue_ready`=0 for 5 cycles during the first issue → fields and `issue_valid` are stable all 5 cycles, and exactly one handshake is counted when ready rises.
- Full program: load all 16 words with non-halt values → exactly 16 issues, then `done` with `pc`=15 and no wrap to 0.
- Ignored inputs: `start` and `prog_we` while busy → no restart and no memory change; rerunning the program matches the original results.
- Mid-run reset: `rst` during ISSUE → next cycle every output is 0 and state is IDLE. A subsequent `start` halts immediately because memory was cleared.

Source files
------------

// File: rtl/instr_sequencer.sv
// Program sequencer: loadable program memory, pc stepping and valid/ready issue of decoded fields.
// Optional single-step mode is enabled by defining INSTR_SEQUENCER_SINGLE_STEP_EN.
module instr_sequencer #(
  parameter int DEPTH = 16,
  parameter int PC_W  = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PC_W-1:0] prog_addr,
  input  logic [4:0]      prog_data,
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic            issue_ready,
  output logic            issue_valid,
  output logic [1:0]      number,
  output logic            reg_in,
  output logic            oper,
  output logic [PC_W-1:0] pc,
  output logic            busy,
  output logic            done
);

  localparam logic [4:0]      HALT_WORD = 5'b10000;
  localparam logic [PC_W-1:0] LAST_PC   = PC_W'(DEPTH - 1);

`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE, S_PAUSE} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_DONE} state_t;
`endif

  state_t          state_reg;
  logic [4:0]      mem [DEPTH];
  logic [DEPTH-1:0] word_we;
  logic            prog_open;
  logic [4:0]      fetch_word;

  // The program may only change while nothing is executing.
  assign prog_open  = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign fetch_word = mem[pc];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word_we
      assign word_we[gi] = prog_we && prog_open && (prog_addr == PC_W'(gi));
    end
  endgenerate

  // Reset must refill every word with halt, so the store is a register array.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= HALT_WORD;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (word_we[i]) mem[i] <= prog_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= S_IDLE;
      issue_valid <= 1'b0;
      number      <= 2'b00;
      reg_in      <= 1'b0;
      oper        <= 1'b0;
      pc          <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE, S_DONE: begin
          if (start) begin
            pc        <= '0;
            done      <= 1'b0;
            busy      <= 1'b1;
            state_reg <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (fetch_word[4]) begin
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= S_DONE;
          end else begin
            number      <= fetch_word[3:2];
            reg_in      <= fetch_word[1];
            oper        <= fetch_word[0];
            issue_valid <= 1'b1;
            state_reg   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // issue_valid is always high here, so ready alone completes the handshake.
          if (issue_ready) begin
            issue_valid <= 1'b0;
            if (pc == LAST_PC) begin
              busy      <= 1'b0;
              done      <= 1'b1;
              state_reg <= S_DONE;
            end else begin
              pc <= pc + 1'b1;
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
              state_reg <= S_PAUSE;
`else
              state_reg <= S_FETCH;
`endif
            end
          end
        end
`ifdef INSTR_SEQUENCER_SINGLE_STEP_EN
        S_PAUSE: begin
          if (step) state_reg <= S_FETCH;
        end
`endif
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: directed scenarios plus randomized programs
// compared against an architectural model of the program memory and execution rules.
module tb_instr_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       prog_we = 1'b0;
  logic [3:0] prog_addr = '0;
  logic [4:0] prog_data = '0;
  logic       issue_ready = 1'b0;
  logic       issue_valid;
  logic [1:0] number;
  logic       reg_in;
  logic       oper;
  logic [3:0] pc;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [4:0] model_mem [16];
  logic [3:0] exp_q [$];
  int         exp_pc;

  instr_sequencer #(.DEPTH(16), .PC_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_data(prog_data),
    .issue_ready(issue_ready), .issue_valid(issue_valid),
    .number(number), .reg_in(reg_in), .oper(oper),
    .pc(pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) model_mem[i] = 5'b10000;
  endtask

  task automatic write_word(input logic [3:0] a, input logic [4:0] d);
    prog_we = 1'b1; prog_addr = a; prog_data = d;
    tick();
    prog_we = 1'b0;
    model_mem[a] = d;
    $display("write addr=%0d data=%02h", a, d);
  endtask

  // Architectural expectation: run from 0, stop at a halt word or after the last address.
  task automatic build_expected();
    exp_q.delete();
    exp_pc = 0;
    for (int a = 0; a < 16; a++) begin
      exp_pc = a;
      if (model_mem[a][4]) return;
      exp_q.push_back(model_mem[a][3:0]);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({issue_valid, number, reg_in, oper, pc, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL %s: outputs=%03h required=000", name,
               {issue_valid, number, reg_in, oper, pc, busy, done});
    end
  endtask

  // Runs the loaded program from a start pulse, recording every handshake.
  task automatic run_program(input string name, input bit rand_ready, input bit disturb);
    logic [3:0] got_q [$];
    logic       prev_valid, prev_hs;
    logic [3:0] prev_fields;
    build_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
    prev_valid = 1'b0; prev_hs = 1'b0; prev_fields = '0;
    for (int cyc = 0; cyc < 300 && done !== 1'b1; cyc++) begin
      if (prev_valid && !prev_hs) begin
        checks++;
        if (issue_valid !== 1'b1 || {number, reg_in, oper} !== prev_fields) begin
          errors++;
          $display("FAIL %s hold: valid=%b fields=%h required valid=1 fields=%h",
                   name, issue_valid, {number, reg_in, oper}, prev_fields);
        end
      end
      issue_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      if (disturb && busy) begin
        start     = 1'($urandom_range(0, 1));
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = 4'($urandom_range(0, 15));
        prog_data = 5'($urandom_range(0, 31));
      end else begin
        start = 1'b0; prog_we = 1'b0;
      end
      prev_valid  = issue_valid;
      prev_hs     = issue_valid && issue_ready;
      prev_fields = {number, reg_in, oper};
      if (prev_hs) got_q.push_back(prev_fields);
      tick();
    end
    start = 1'b0; prog_we = 1'b0; issue_ready = 1'b0;
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout: done=%b required 1", name, done);
    end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s count: issues=%0d required %0d", name, got_q.size(), exp_q.size());
    end
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s issue%0d: fields=%h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (pc !== 4'(exp_pc) || busy !== 1'b0 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL %s end: pc=%0d busy=%b valid=%b required pc=%0d busy=0 valid=0",
               name, pc, busy, issue_valid, exp_pc);
    end
    $display("run %s: issues=%0d expected=%0d pc=%0d done=%b", name, got_q.size(),
             exp_q.size(), pc, done);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    model_clear();
    check_all_zero("reset");
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || issue_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: busy=%b valid=%b done=%b required 1 0 0", busy, issue_valid, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || issue_valid !== 1'b0 || pc !== 4'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_halt: done=%b valid=%b pc=%0d busy=%b required 1 0 0 0",
               done, issue_valid, pc, busy);
    end
    $display("reset: done=%b pc=%0d", done, pc);
  endtask

  task automatic test_load_and_run();
    write_word(4'd0, 5'h05);
    write_word(4'd1, 5'h0A);
    write_word(4'd2, 5'h10);
    issue_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if ({issue_valid, number, reg_in, oper} !== 5'b1_01_0_1) begin
      errors++;
      $display("FAIL load_first: v/fields=%b required 10101", {issue_valid, number, reg_in, oper});
    end
    tick();
    checks++;
    if (issue_valid !== 1'b0 || pc !== 4'd1) begin
      errors++;
      $display("FAIL load_gap: valid=%b pc=%0d required 0 1", issue_valid, pc);
    end
    tick();
    checks++;
    if ({issue_valid, number, reg_in, oper} !== 5'b1_10_1_0) begin
      errors++;
      $display("FAIL load_second: v/fields=%b required 11010", {issue_valid, number, reg_in, oper});
    end
    tick(); tick();
    checks++;
    if (done !== 1'b1 || pc !== 4'd2 || issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL load_done: done=%b pc=%0d valid=%b required 1 2 0", done, pc, issue_valid);
    end
    issue_ready = 1'b0;
    $display("load_and_run: done=%b pc=%0d", done, pc);
  endtask

  task automatic test_backpressure();
    logic [3:0] held;
    issue_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    held = {number, reg_in, oper};
    checks++;
    if (issue_valid !== 1'b1 || held !== 4'b0101) begin
      errors++;
      $display("FAIL bp_first: valid=%b fields=%h required 1 5", issue_valid, held);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (issue_valid !== 1'b1 || {number, reg_in, oper} !== held || pc !== 4'd0) begin
        errors++;
        $display("FAIL bp_hold%0d: valid=%b fields=%h pc=%0d required 1 %h 0",
                 i, issue_valid, {number, reg_in, oper}, pc, held);
      end
    end
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
    tick(); tick();
    checks++;
    if (pc !== 4'd1 || issue_valid !== 1'b1 || {number, reg_in, oper} !== 4'b1010) begin
      errors++;
      $display("FAIL bp_one_hs: pc=%0d valid=%b fields=%h required 1 1 a",
               pc, issue_valid, {number, reg_in, oper});
    end
    issue_ready = 1'b1;
    for (int i = 0; i < 20 && done !== 1'b1; i++) tick();
    issue_ready = 1'b0;
    checks++;
    if (done !== 1'b1 || pc !== 4'd2) begin
      errors++;
      $display("FAIL bp_done: done=%b pc=%0d required 1 2", done, pc);
    end
    $display("backpressure: done=%b pc=%0d", done, pc);
  endtask

  task automatic test_full_program();
    for (int a = 0; a < 16; a++) write_word(4'(a), {1'b0, 4'($urandom_range(0, 15))});
    run_program("full", 1'b1, 1'b0);
    tick(); tick(); tick();
    checks++;
    if (pc !== 4'd15 || done !== 1'b1) begin
      errors++;
      $display("FAIL full_nowrap: pc=%0d done=%b required 15 1", pc, done);
    end
  endtask

  task automatic test_ignored_inputs();
    for (int a = 0; a < 16; a++)
      write_word(4'(a), {($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15))});
    write_word(4'd0, 5'h03);
    run_program("disturbed", 1'b1, 1'b1);
    run_program("rerun", 1'b1, 1'b0);
  endtask

  task automatic test_mid_run_reset();
    write_word(4'd0, 5'h05);
    issue_ready = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (issue_valid !== 1'b1) begin
      errors++;
      $display("FAIL midrst_issue: valid=%b required 1", issue_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    model_clear();
    check_all_zero("midrst_zero");
    start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (issue_valid !== 1'b0) begin
      errors++;
      $display("FAIL midrst_fetch: valid=%b required 0", issue_valid);
    end
    tick();
    checks++;
    if (done !== 1'b1 || issue_valid !== 1'b0 || pc !== 4'd0) begin
      errors++;
      $display("FAIL midrst_halt: done=%b valid=%b pc=%0d required 1 0 0", done, issue_valid, pc);
    end
    $display("mid_run_reset: done=%b pc=%0d", done, pc);
  endtask

  task automatic test_random_programs();
    for (int r = 0; r < 6; r++) begin
      int n = $urandom_range(1, 20);
      for (int k = 0; k < n; k++)
        write_word(4'($urandom_range(0, 15)),
                   {($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15))});
      run_program($sformatf("random%0d", r), 1'b1, 1'b0);
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_load_and_run();
    test_backpressure();
    test_full_program();
    test_ignored_inputs();
    test_mid_run_reset();
    test_random_programs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
